// File: rtl/onstate_ontransit_pkg.sv
// onstate_ontransit_pkg: state encodings and error codes shared by the run engine and its initiator
package onstate_ontransit_pkg;
  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_RUN  = 2'd1,
    ENG_LAST = 2'd2
  } eng_state_e;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACK    = 3'd1,
    S_RUN    = 3'd2,
    S_DROP   = 3'd3,
    S_WAIT_F = 3'd4,
    S_CLOSE  = 3'd5,
    S_ERR    = 3'd6
  } init_state_e;
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ACK_TMO  = 3'd1;
  localparam logic [2:0] ERR_NO_G     = 3'd2;
  localparam logic [2:0] ERR_NO_F     = 3'd3;
  localparam logic [2:0] ERR_F_STUCK  = 3'd4;
  localparam logic [2:0] ERR_SPURIOUS = 3'd5;
  localparam logic [2:0] ERR_ZERO_LEN = 3'd6;
endpackage

// File: rtl/oto_err_latch.sv
// oto_err_latch: sticky first-error capture; clear wins over a simultaneous new error
module oto_err_latch
  import onstate_ontransit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set,
  input  logic [2:0] code_in,
  input  logic       clr,
  output logic       err,
  output logic [2:0] err_code
);
  logic       err_q, err_d;
  logic [2:0] code_q, code_d;
  always_comb begin
    err_d  = clr ? 1'b0 : (set && !err_q) ? 1'b1 : err_q;
    code_d = clr ? ERR_NONE : (set && !err_q) ? code_in : code_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
    end
  end
  assign err      = err_q;
  assign err_code = code_q;
endmodule

// File: rtl/onstate_ontransit_initiator.sv
// onstate_ontransit_initiator: drives engine do for len acked RUN cycles, then checks g, f and return to IDLE
module onstate_ontransit_initiator
  import onstate_ontransit_pkg::*;
#(
  parameter int LW  = 8,
  parameter int CW  = 16,
  parameter int TMO = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          clr_err,
  input  logic          r,
  input  logic          g,
  input  logic          f,
  output logic          do_req,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [CW-1:0] job_count
);
  localparam int TW = $clog2(TMO + 1);
  init_state_e   state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          do_req_q, do_req_d;
  logic          done_q, done_d;
  logic [CW-1:0] job_q, job_d;
  logic          err_set;
  logic [2:0]    err_in;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    do_req_d = do_req_q;
    done_d   = 1'b0;
    job_d    = job_q;
    err_set  = 1'b0;
    err_in   = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (start && len != '0) begin
          cnt_d    = len;
          do_req_d = 1'b1;
          state_d  = S_ACK;
        end else if (start) begin
          err_set = 1'b1;
          err_in  = ERR_ZERO_LEN;
        end else if (r || f) begin
          err_set = 1'b1;
          err_in  = ERR_SPURIOUS;
          state_d = S_ERR;
        end
      end
      S_ACK: begin
        if (r) begin
          cnt_d    = cnt_q - LW'(1);
          do_req_d = cnt_q != LW'(1);
          state_d  = (cnt_q == LW'(1)) ? S_DROP : S_RUN;
        end else if (tmo_q == TW'(TMO - 1)) begin
          err_set = 1'b1;
          err_in  = ERR_ACK_TMO;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RUN: begin
        if (!r) begin
          err_set = 1'b1;
          err_in  = ERR_NO_F;
          state_d = S_ERR;
        end else begin
          cnt_d    = cnt_q - LW'(1);
          do_req_d = cnt_q != LW'(1);
          state_d  = (cnt_q == LW'(1)) ? S_DROP : S_RUN;
        end
      end
      S_DROP: begin
        state_d = (g && r) ? S_WAIT_F : S_ERR;
        err_set = !(g && r);
        err_in  = ERR_NO_G;
      end
      S_WAIT_F: begin
        state_d = (f && !r) ? S_CLOSE : S_ERR;
        err_set = !(f && !r);
        err_in  = ERR_NO_F;
      end
      S_CLOSE: begin
        if (!f) begin
          done_d  = 1'b1;
          job_d   = job_q + CW'(1);
          state_d = S_IDLE;
        end else begin
          err_set = 1'b1;
          err_in  = ERR_F_STUCK;
          state_d = S_ERR;
        end
      end
      S_ERR: state_d = clr_err ? S_IDLE : S_ERR;
      default: state_d = S_IDLE;
    endcase
    // the engine is released as soon as any fault is detected
    if (state_d == S_ERR) do_req_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      do_req_q <= 1'b0;
      done_q   <= 1'b0;
      job_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      do_req_q <= do_req_d;
      done_q   <= done_d;
      job_q    <= job_d;
    end
  end
  oto_err_latch u_err (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (err_set),
    .code_in  (err_in),
    .clr      (clr_err),
    .err      (err),
    .err_code (err_code)
  );
  assign do_req    = do_req_q;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
  assign job_count = job_q;
endmodule
